// File: rtl/o_acc_rescale.sv
// Flash-attention running-output accumulator: per KV tile, rescales each stored O row by its
// row coefficient and adds the streamed P*V row, saturating in Q3.12.
module o_acc_rescale #(
   parameter int D_W  = 16,
   parameter int FRAC = 12,
   parameter int TIL  = 16,
   parameter int DK   = 16
) (
   input  logic                     I_CLK,
   input  logic                     I_RST,
   input  logic                     I_FIRST,
   input  logic                     I_COEF_VLD,
   output logic                     O_COEF_RDY,
   input  logic [D_W*TIL-1:0]       I_COEFFICIENT,
   input  logic                     I_PV_VLD,
   output logic                     O_PV_RDY,
   input  logic [D_W*DK-1:0]        I_PV_ROW,
   output logic                     O_TILE_DONE,
   input  logic [$clog2(TIL)-1:0]   I_RD_ROW,
   output logic [D_W*DK-1:0]        O_RD_DATA
);

   localparam int CNT_W = $clog2(TIL);
   localparam logic signed [2*D_W-1:0] RND  = {{(2*D_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
   localparam logic signed [2*D_W-1:0] SMAX = {{(D_W+1){1'b0}}, {(D_W-1){1'b1}}};
   localparam logic signed [2*D_W-1:0] SMIN = {{(D_W+1){1'b1}}, {(D_W-1){1'b0}}};
   localparam logic [D_W-1:0] MAXV = {1'b0, {(D_W-1){1'b1}}};
   localparam logic [D_W-1:0] MINV = {1'b1, {(D_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t              stateQ, stateD;
   logic [CNT_W-1:0]    cntQ, cntD;
   logic [D_W*TIL-1:0]  coefQ, coefD;
   logic                firstQ, firstD;
   logic [D_W*DK-1:0]   bufQ [TIL];
   logic [D_W*DK-1:0]   rdDataQ;
   logic [D_W*DK-1:0]   newRow;
   logic [D_W-1:0]      rowCoef;
   logic                wrEn;

   // Rounded (half up) and saturated rescale, then a saturating add of the P*V element.
   function automatic logic [D_W-1:0] updateElem(input logic [D_W-1:0] coef,
                                                  input logic [D_W-1:0] old,
                                                  input logic [D_W-1:0] pv,
                                                  input logic           first);
      logic signed [2*D_W-1:0] prod;
      logic signed [2*D_W-1:0] rnd;
      logic [D_W-1:0]          s;
      logic [D_W:0]            sum;
      prod = $signed({{D_W{coef[D_W-1]}}, coef}) * $signed({{D_W{old[D_W-1]}}, old});
      rnd  = (prod + RND) >>> FRAC;
      if (first)
         s = '0;
      else if (rnd > SMAX)
         s = MAXV;
      else if (rnd < SMIN)
         s = MINV;
      else
         s = rnd[D_W-1:0];
      sum = {s[D_W-1], s} + {pv[D_W-1], pv};
      if (sum[D_W] != sum[D_W-1])
         return sum[D_W] ? MINV : MAXV;
      return sum[D_W-1:0];
   endfunction

   assign wrEn = (stateQ == ACCUM) && I_PV_VLD;

   always_comb begin
      rowCoef = coefQ[int'(cntQ)*D_W +: D_W];
      newRow  = '0;
      for (int c = 0; c < DK; c++) begin
         newRow[c*D_W +: D_W] = updateElem(rowCoef, bufQ[cntQ][c*D_W +: D_W],
                                           I_PV_ROW[c*D_W +: D_W], firstQ);
      end
   end

   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         stateQ <= IDLE;
         cntQ   <= '0;
         coefQ  <= '0;
         firstQ <= 1'b0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
         coefQ  <= coefD;
         firstQ <= firstD;
      end
   end

   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         IDLE:    if (I_COEF_VLD) stateD = ACCUM;
         ACCUM:   if (I_PV_VLD && cntQ == CNT_W'(TIL-1)) stateD = DONE;
         DONE:    stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   // Coefficients and the first-tile flag are captured only at the IDLE handshake.
   always_comb begin
      cntD   = cntQ;
      coefD  = coefQ;
      firstD = firstQ;
      if (stateQ == IDLE && I_COEF_VLD) begin
         cntD   = '0;
         coefD  = I_COEFFICIENT;
         firstD = I_FIRST;
      end else if (wrEn) begin
         cntD = (cntQ == CNT_W'(TIL-1)) ? '0 : cntQ + CNT_W'(1);
      end
   end

   always_comb begin
      O_COEF_RDY  = 1'b0;
      O_PV_RDY    = 1'b0;
      O_TILE_DONE = 1'b0;
      unique case (stateQ)
         IDLE:    O_COEF_RDY  = 1'b1;
         ACCUM:   O_PV_RDY    = 1'b1;
         DONE:    O_TILE_DONE = 1'b1;
         default: ;
      endcase
   end

   // Read samples the buffer before this edge's write lands, so a same-row read sees old data.
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         for (int r = 0; r < TIL; r++) bufQ[r] <= '0;
         rdDataQ <= '0;
      end else begin
         if (wrEn) bufQ[cntQ] <= newRow;
         rdDataQ <= bufQ[I_RD_ROW];
      end
   end

   assign O_RD_DATA = rdDataQ;

endmodule
